// File: rtl/led_seq_multi.sv
// Multi-channel LED sequencer: a shared prescaler strobes NCH counters, each
// running up, down, Gray or hold, with a host write port for mode/state.
module led_seq_multi #(
    parameter int DIVIDE = 10000,
    parameter int NCH    = 2,
    parameter int WIDTH  = 2,
    parameter int CHW    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 wr_en,
    input  logic [CHW-1:0]       wr_ch,
    input  logic [1:0]           wr_mode,
    input  logic                 wr_load,
    input  logic [WIDTH-1:0]     wr_state,
    output logic [NCH*WIDTH-1:0] leds,
    output logic                 tick,
    output logic [NCH-1:0]       wrap
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    localparam logic [31:0]      LAST = 32'(DIVIDE - 1);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic [31:0]      pcount;
    logic [WIDTH-1:0] cnt      [NCH];
    logic [WIDTH-1:0] cnt_nxt  [NCH];
    mode_t            mode     [NCH];
    mode_t            mode_nxt [NCH];
    logic [NCH-1:0]   wrap_nxt;

    assign tick = run && (pcount == LAST);

    // Prescaler freezes (rather than clears) while run is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcount <= '0;
        end else if (run) begin
            pcount <= (pcount == LAST) ? '0 : pcount + 32'd1;
        end
    end

    // A write to a channel takes priority over that channel's tick advance.
    always_comb begin
        wrap_nxt = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt_nxt[k]  = cnt[k];
            mode_nxt[k] = mode[k];
            if (wr_en && (wr_ch == CHW'(k))) begin
                mode_nxt[k] = mode_t'(wr_mode);
                if (wr_load) begin
                    cnt_nxt[k] = wr_state;
                end
            end else if (tick) begin
                case (mode[k])
                    MODE_UP, MODE_GRAY: begin
                        cnt_nxt[k]  = cnt[k] + WIDTH'(1);
                        wrap_nxt[k] = (cnt[k] == ONES);
                    end
                    MODE_DOWN: begin
                        cnt_nxt[k]  = cnt[k] - WIDTH'(1);
                        wrap_nxt[k] = (cnt[k] == '0);
                    end
                    default: begin
                        cnt_nxt[k] = cnt[k];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                cnt[k]  <= '0;
                mode[k] <= MODE_UP;
            end
            wrap <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cnt[k]  <= cnt_nxt[k];
                mode[k] <= mode_nxt[k];
            end
            wrap <= wrap_nxt;
        end
    end

    // Gray mode keeps a binary counter and encodes it only for display.
    always_comb begin
        leds = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mode[k] == MODE_GRAY) begin
                leds[k*WIDTH +: WIDTH] = cnt[k] ^ (cnt[k] >> 1);
            end else begin
                leds[k*WIDTH +: WIDTH] = cnt[k];
            end
        end
    end

endmodule

// File: doc/led_seq_multi.md
Name: led_seq_multi

Overview:
- Parametrised successor to the single-channel divide-and-count LED driver.
- A shared prescaler divides `clk` by DIVIDE. On each prescaler tick, NCH independent WIDTH-bit channel counters advance, each according to its own mode: up, down, Gray or hold.
- A write port lets the host set a channel's mode and optionally load its state at runtime.
- Drives board LEDs directly; sits at top level beside the other LED/debug blocks.

Parameters:
- DIVIDE, 10000, prescaler period in `clk` cycles (≥1).
- NCH, 2, number of channels (≥1).
- WIDTH, 2, bits per channel counter (≥1).
- CHW, 1, width of the channel-select field; must satisfy 2**CHW ≥ NCH.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `run`  in  1  global enable for the prescaler.
- `wr_en`  in  1  one-cycle write strobe.
- `wr_ch`  in  CHW  target channel of the write.
- `wr_mode`  in  2  new mode: 0 = up, 1 = down, 2 = Gray, 3 = hold.
- `wr_load`  in  1  when 1, the write also loads `wr_state` into the channel counter.
- `wr_state`  in  WIDTH  load value (binary).
- `leds`  out  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `tick`  out  1  prescaler strobe.
- `wrap`  out  NCH  per-channel wrap pulse, registered.

Behaviour:
- Reset (`rst_n`=0 at a posedge):
  - prescaler count = 0;
  - every channel counter `cnt` = 0;
  - every mode = 0 (up);
  - `wrap` = 0.
  - Consequently `leds` = 0 and `tick` = 0 in the following cycle.
  - Reset overrides writes and ticks in the same cycle.
- Prescaler:
  - 32-bit count.
  - If `run`=1: the count increments each cycle. At DIVIDE-1 it returns to 0.
  - If `run`=0: the count holds its value (no clear).
- `tick` is combinational: `tick` = `run` && (count == DIVIDE-1).
  - With DIVIDE=1, `tick` = `run` every cycle.
- Channel advance, at a posedge with `tick`=1, for each channel k not being written:
  - mode 0 (up): `cnt` + 1, wrapping mod 2**WIDTH.
  - mode 1 (down): `cnt` - 1, wrapping mod 2**WIDTH.
  - mode 2 (Gray): `cnt` + 1 (binary).
  - mode 3 (hold): unchanged.
- Output mapping:
  - `leds` slice k = `cnt` ^ (`cnt` >> 1) when mode k = 2.
  - Otherwise `leds` slice k = `cnt`.
  - Combinational from the registers, so a mode change alters `leds` in the cycle after the write.
- Wrap:
  - `wrap`[k] goes to 1 for exactly one cycle after an advance edge where `cnt` went from all-ones to 0 (modes 0 and 2), or from 0 to all-ones (mode 1).
  - Otherwise `wrap`[k] = 0.
- Write (`wr_en`=1, `wr_ch` < NCH):
  - At the posedge, mode[`wr_ch`] = `wr_mode`.
  - If `wr_load`=1, `cnt`[`wr_ch`] = `wr_state`.
  - The `wr_state` load is binary; in Gray mode the displayed value is its Gray encoding.
  - `wr_ch` ≥ NCH: write ignored entirely.
- Write colliding with a tick on the same channel:
  - The write wins; that channel does not advance and `wrap`[k] = 0.
  - With `wr_load`=0, `cnt` is held for that edge.
  - Other channels advance normally.
- Latency: `leds` changes one cycle after the posedge at which `tick`=1.
- Prescaler arithmetic: compare against DIVIDE-1 as a 32-bit constant.

Test Plan:
- Reset and up-count, DIVIDE=4, NCH=2, WIDTH=2: deassert `rst_n`, `run`=1.
  - Required: `tick` high on cycles 3, 7, 11, …
  - Required: `leds` = 0x0 → 0x5 → 0xA → 0xF → 0x0.
  - Required: `wrap` = 2'b11 for one cycle after the 4th tick.
- Down and Gray modes:
  - Write ch1 with mode 1 and `wr_load`=1, `wr_state`=0.
  - Write ch0 with mode 2.
  - Required over ticks: ch1 = 3, 2, 1, 0 with `wrap`[1] asserted after the 0→3 step; ch0 `leds` = 1, 3, 2, 0 (Gray of 1, 2, 3, 0).
- Hold and run gating:
  - Set ch0 mode 3 → ch0 `leds` frozen while ch1 keeps counting.
  - Drop `run` for 10 cycles mid-period (count = 2) → no `tick`.
  - Raise `run` → next `tick` occurs after exactly 1 more cycle.
- Write/tick collision:
  - Write ch0 with `wr_load`=1, `wr_state`=2 on the same cycle `tick`=1 → ch0 = 2 next cycle, `wrap`[0] = 0.
  - Ch1 advances as normal.
- Invalid channel and mid-run reset:
  - With NCH=3, CHW=2: write `wr_ch`=3 → no state or mode change.
  - Assert `rst_n`=0 for 1 cycle mid-count together with `wr_en`=1 → all counters, modes, `wrap` and prescaler = 0; the write is lost.
- DIVIDE=1:
  - `tick` is constant 1 while `run`=1.
  - Ch0 in up mode increments every cycle, and `wrap`[0] pulses every 4 cycles.
